// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback. All strobes are decoded combinationally from the current state
// and the IR contents. Branches are resolved from the ALU zero flag and funct3.
module multicycle_control #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] instr,
   input  logic            alu_zero,
   input  logic            mem_ready,
   output logic [1:0]      aluop,
   output logic            mem_valid,
   output logic            mem_we,
   output logic            mem_src,
   output logic            ir_write,
   output logic            pc_write,
   output logic [1:0]      pc_src,
   output logic [1:0]      alu_a_sel,
   output logic            alu_b_sel,
   output logic            reg_write,
   output logic [1:0]      wb_sel,
   output logic            illegal,
   output logic [XLEN-1:0] instret
);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB_ALU,
      S_ADDR,
      S_MEM_RD,
      S_WB_MEM,
      S_MEM_WR,
      S_BRANCH,
      S_JAL,
      S_JALR,
      S_HALT
   } state_t;

   state_t state;
   state_t state_next;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       taken;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // Only opcode and funct3 steer the controller; the rest of the IR is
   // consumed by the datapath.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr[XLEN-1:15], instr[11:7]};

   // Zero flag is inverted for BNE/BLT/BLTU (funct3[0] xor funct3[2]).
   assign taken = alu_zero ^ funct3[0] ^ funct3[2];

   // State register; reset abandons any outstanding memory request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Retired-instruction counter: one count per PC update, wraps naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         instret <= '0;
      end else if (pc_write) begin
         instret <= instret + {{(XLEN-1){1'b0}}, 1'b1};
      end
   end

   // Next-state and strobe decode; everything idles at zero unless set below.
   always_comb begin
      state_next = state;
      aluop      = 2'b00;
      mem_valid  = 1'b0;
      mem_we     = 1'b0;
      mem_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'd0;
      alu_a_sel  = 2'd0;
      alu_b_sel  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = 2'd0;
      illegal    = 1'b0;
      case (state)
         S_IDLE: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_R, OP_I, OP_LUI, OP_AUIPC: state_next = S_EXEC;
               OP_LOAD, OP_STORE:            state_next = S_ADDR;
               OP_BR:                        state_next = S_BRANCH;
               OP_JAL:                       state_next = S_JAL;
               OP_JALR:                      state_next = S_JALR;
               default:                      state_next = S_HALT;
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_R: begin
                  aluop = 2'b10;
               end
               OP_I: begin
                  aluop     = 2'b10;
                  alu_b_sel = 1'b1;
               end
               OP_LUI: begin
                  alu_a_sel = 2'd2;
                  alu_b_sel = 1'b1;
               end
               OP_AUIPC: begin
                  alu_a_sel = 2'd1;
                  alu_b_sel = 1'b1;
               end
               default: ;
            endcase
            state_next = S_WB_ALU;
         end
         S_WB_ALU: begin
            reg_write  = 1'b1;
            pc_write   = 1'b1;
            state_next = S_FETCH;
         end
         S_ADDR: begin
            alu_b_sel  = 1'b1;
            state_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_valid = 1'b1;
            mem_src   = 1'b1;
            if (mem_ready) begin
               state_next = S_WB_MEM;
            end
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            wb_sel     = 2'd1;
            pc_write   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WR: begin
            mem_valid = 1'b1;
            mem_we    = 1'b1;
            mem_src   = 1'b1;
            if (mem_ready) begin
               pc_write   = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_BRANCH: begin
            aluop      = 2'b01;
            pc_write   = 1'b1;
            pc_src     = {1'b0, taken};
            state_next = S_FETCH;
         end
         S_JAL: begin
            reg_write  = 1'b1;
            wb_sel     = 2'd2;
            pc_write   = 1'b1;
            pc_src     = 2'd1;
            state_next = S_FETCH;
         end
         S_JALR: begin
            alu_b_sel  = 1'b1;
            reg_write  = 1'b1;
            wb_sel     = 2'd2;
            pc_write   = 1'b1;
            pc_src     = 2'd2;
            state_next = S_FETCH;
         end
         S_HALT: begin
            illegal = 1'b1;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a table of single instructions
// with constant expectations, a per-instruction micro-op reference model fed
// with random instructions and wait states, and hand sequences for wait
// states, HALT and reset during a store.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr = 32'h0;
   logic        alu_zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [1:0]  aluop;
   logic        mem_valid, mem_we, mem_src, ir_write, pc_write;
   logic [1:0]  pc_src, alu_a_sel, wb_sel;
   logic        alu_b_sel, reg_write, illegal;
   logic [31:0] instret;

   multicycle_control #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .instr(instr), .alu_zero(alu_zero),
      .mem_ready(mem_ready), .aluop(aluop), .mem_valid(mem_valid),
      .mem_we(mem_we), .mem_src(mem_src), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
      .alu_b_sel(alu_b_sel), .reg_write(reg_write), .wb_sel(wb_sel),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] aluop;
      logic       mem_valid;
      logic       mem_we;
      logic       mem_src;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic [1:0] alu_a_sel;
      logic       alu_b_sel;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic       illegal;
   } ctrl_t;

   ctrl_t dut_ctrl;
   assign dut_ctrl = {aluop, mem_valid, mem_we, mem_src, ir_write, pc_write,
                      pc_src, alu_a_sel, alu_b_sel, reg_write, wb_sel, illegal};

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_instret = 32'h0;

   ctrl_t exp_q[$];
   logic  rdy_q[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void push(input ctrl_t c, input logic r);
      exp_q.push_back(c);
      rdy_q.push_back(r);
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Reference model: expands one instruction into its expected per-cycle
   // strobe vectors and the mem_ready value to drive on each cycle.
   // Memory phases get their wait cycles followed by one completing cycle;
   // all other cycles get a random mem_ready, which must be ignored.
   task automatic build(input logic [31:0] ins, input logic z, input int fw, input int mw);
      ctrl_t c;
      logic [6:0] op;
      logic [2:0] f3;
      logic tk;
      op = ins[6:0];
      f3 = ins[14:12];
      exp_q.delete();
      rdy_q.delete();
      for (int i = 0; i < fw; i++) begin
         c = '0; c.mem_valid = 1'b1; push(c, 1'b0);
      end
      c = '0; c.mem_valid = 1'b1; c.ir_write = 1'b1; push(c, 1'b1);
      c = '0; push(c, rbit());
      case (op)
         7'h33, 7'h13, 7'h37, 7'h17: begin
            c = '0;
            if (op == 7'h33 || op == 7'h13) c.aluop = 2'b10;
            if (op != 7'h33) c.alu_b_sel = 1'b1;
            if (op == 7'h37) c.alu_a_sel = 2'd2;
            if (op == 7'h17) c.alu_a_sel = 2'd1;
            push(c, rbit());
            c = '0; c.reg_write = 1'b1; c.pc_write = 1'b1; push(c, rbit());
         end
         7'h03: begin
            c = '0; c.alu_b_sel = 1'b1; push(c, rbit());
            for (int i = 0; i < mw; i++) begin
               c = '0; c.mem_valid = 1'b1; c.mem_src = 1'b1; push(c, 1'b0);
            end
            c = '0; c.mem_valid = 1'b1; c.mem_src = 1'b1; push(c, 1'b1);
            c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd1; c.pc_write = 1'b1; push(c, rbit());
         end
         7'h23: begin
            c = '0; c.alu_b_sel = 1'b1; push(c, rbit());
            for (int i = 0; i < mw; i++) begin
               c = '0; c.mem_valid = 1'b1; c.mem_we = 1'b1; c.mem_src = 1'b1; push(c, 1'b0);
            end
            c = '0; c.mem_valid = 1'b1; c.mem_we = 1'b1; c.mem_src = 1'b1; c.pc_write = 1'b1;
            push(c, 1'b1);
         end
         7'h63: begin
            // BEQ/BGE/BGEU take when the compare result is zero; BNE/BLT/BLTU otherwise.
            case (f3)
               3'b000, 3'b101, 3'b111: tk = z;
               default:                tk = ~z;
            endcase
            c = '0; c.aluop = 2'b01; c.pc_write = 1'b1; c.pc_src = {1'b0, tk}; push(c, rbit());
         end
         7'h6F: begin
            c = '0; c.reg_write = 1'b1; c.wb_sel = 2'd2; c.pc_write = 1'b1; c.pc_src = 2'd1;
            push(c, rbit());
         end
         7'h67: begin
            c = '0; c.alu_b_sel = 1'b1; c.reg_write = 1'b1; c.wb_sel = 2'd2;
            c.pc_write = 1'b1; c.pc_src = 2'd2; push(c, rbit());
         end
         default: ;
      endcase
   endtask

   // Applies the model's cycles (up to limit, -1 = all) starting at a negedge
   // with the DUT in FETCH; strobes and instret are compared every cycle.
   task automatic run_model(input logic [31:0] ins, input logic z, input int fw,
                            input int mw, input int limit);
      int n;
      build(ins, z, fw, mw);
      n = (limit < 0) ? exp_q.size() : limit;
      for (int i = 0; i < n; i++) begin
         instr = ins;
         alu_zero = z;
         mem_ready = rdy_q[i];
         #1;
         chk($sformatf("model_ctrl[%0d]", i), 64'(dut_ctrl), 64'(exp_q[i]));
         chk($sformatf("model_instret[%0d]", i), 64'(instret), 64'(exp_instret));
         if (exp_q[i].pc_write) exp_instret = exp_instret + 32'd1;
         @(negedge clk);
      end
      $display("model  instr=%h zero=%0d fw=%0d mw=%0d cycles=%0d instret=%0d",
               ins, z, fw, mw, n, exp_instret);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      exp_instret = 32'h0;
      #1;
      chk("reset_ctrl", 64'(dut_ctrl), 64'h0);
      chk("reset_instret", 64'(instret), 64'h0);
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        z;
      int          cpi;
      logic [1:0]  aluop3;
      logic [1:0]  pc_src;
      logic        reg_write;
      logic [1:0]  wb_sel;
   } vec_t;

   vec_t vecs[13];

   // One table entry with zero-wait memory: measure cycles until pc_write and
   // check the third-cycle aluop plus the retire-cycle strobes.
   task automatic run_vec(input int k);
      int cyc;
      logic [1:0] a3;
      logic done;
      done = 1'b0;
      a3 = 2'bxx;
      cyc = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         instr = vecs[k].ins;
         alu_zero = vecs[k].z;
         mem_ready = 1'b1;
         #1;
         if (c == 1) chk($sformatf("vec%0d_instret", k), 64'(instret), 64'(exp_instret));
         if (c == 3) a3 = aluop;
         if (pc_write) begin
            done = 1'b1;
            cyc = c;
            chk($sformatf("vec%0d_cpi", k), 64'(cyc), 64'(vecs[k].cpi));
            chk($sformatf("vec%0d_aluop", k), 64'(a3), 64'(vecs[k].aluop3));
            chk($sformatf("vec%0d_pc_src", k), 64'(pc_src), 64'(vecs[k].pc_src));
            chk($sformatf("vec%0d_reg_write", k), 64'(reg_write), 64'(vecs[k].reg_write));
            chk($sformatf("vec%0d_wb_sel", k), 64'(wb_sel), 64'(vecs[k].wb_sel));
            exp_instret = exp_instret + 32'd1;
         end
         @(negedge clk);
      end
      if (!done) chk($sformatf("vec%0d_timeout", k), 64'd0, 64'd1);
      $display("vector %0d instr=%h zero=%0d cycles=%0d", k, vecs[k].ins, vecs[k].z, cyc);
   endtask

   logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67};
   logic [2:0] br_f3[6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      ctrl_t c;
      //            instr         z     cpi aluop pc_src rw    wb
      vecs[0]  = '{32'h002081B3, 1'b0, 4, 2'b10, 2'd0, 1'b1, 2'd0};  // add
      vecs[1]  = '{32'h00508093, 1'b0, 4, 2'b10, 2'd0, 1'b1, 2'd0};  // addi
      vecs[2]  = '{32'h123450B7, 1'b0, 4, 2'b00, 2'd0, 1'b1, 2'd0};  // lui
      vecs[3]  = '{32'h00001097, 1'b0, 4, 2'b00, 2'd0, 1'b1, 2'd0};  // auipc
      vecs[4]  = '{32'h0000A103, 1'b0, 5, 2'b00, 2'd0, 1'b1, 2'd1};  // lw
      vecs[5]  = '{32'h0020A023, 1'b0, 4, 2'b00, 2'd0, 1'b0, 2'd0};  // sw
      vecs[6]  = '{32'h00208063, 1'b1, 3, 2'b01, 2'd1, 1'b0, 2'd0};  // beq taken
      vecs[7]  = '{32'h00209063, 1'b0, 3, 2'b01, 2'd1, 1'b0, 2'd0};  // bne taken
      vecs[8]  = '{32'h00209063, 1'b1, 3, 2'b01, 2'd0, 1'b0, 2'd0};  // bne not taken
      vecs[9]  = '{32'h0020F063, 1'b1, 3, 2'b01, 2'd1, 1'b0, 2'd0};  // bgeu taken
      vecs[10] = '{32'h0020C063, 1'b1, 3, 2'b01, 2'd0, 1'b0, 2'd0};  // blt not taken
      vecs[11] = '{32'h008000EF, 1'b0, 3, 2'b00, 2'd1, 1'b1, 2'd2};  // jal
      vecs[12] = '{32'h000080E7, 1'b0, 3, 2'b00, 2'd2, 1'b1, 2'd2};  // jalr

      do_reset();
      for (int k = 0; k < 13; k++) run_vec(k);

      // Load with three wait states in MEM_RD.
      run_model(32'h0000A103, 1'b0, 0, 3, -1);
      // Fetch wait states too.
      run_model(32'h002081B3, 1'b0, 2, 0, -1);

      // Random instruction stream.
      for (int n = 0; n < 40; n++) begin
         ins = $urandom;
         ins[6:0] = ops[$urandom_range(0, 8)];
         if (ins[6:0] == 7'h63) ins[14:12] = br_f3[$urandom_range(0, 5)];
         run_model(ins, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
      end

      // Reset while a store waits: fetch, decode, addr, two MEM_WR waits.
      run_model(32'h0020A023, 1'b0, 0, 2, 5);
      reset = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      exp_instret = 32'h0;
      #1;
      chk("rst_mid_ctrl", 64'(dut_ctrl), 64'h0);
      chk("rst_mid_instret", 64'(instret), 64'h0);
      @(negedge clk);
      #1;
      c = '0; c.mem_valid = 1'b1;
      chk("rst_mid_fetch", 64'(dut_ctrl), 64'(c));
      @(negedge clk);
      $display("reset  during MEM_WR wait, fetch resumed");

      // One retired instruction, then an unsupported opcode halts.
      run_model(32'h002081B3, 1'b0, 0, 0, -1);
      run_model(32'h0000007F, 1'b0, 0, 0, -1);
      for (int i = 0; i < 10; i++) begin
         mem_ready = rbit();
         #1;
         c = '0; c.illegal = 1'b1;
         chk($sformatf("halt_ctrl[%0d]", i), 64'(dut_ctrl), 64'(c));
         chk($sformatf("halt_instret[%0d]", i), 64'(instret), 64'(exp_instret));
         @(negedge clk);
      end
      $display("halt   held 10 cycles, instret=%0d", exp_instret);
      do_reset();
      $display("reset  after halt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
